// File: rtl/upslv_pkg.sv
// Shared definitions for the upslv register slave: register offsets,
// bus widths, FSM state encoding and the default VERSION value.
package upslv_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned EVT_W  = 8;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

    localparam logic [3:0] OFF_VERSION = 4'd0;
    localparam logic [3:0] OFF_CTRL    = 4'd1;
    localparam logic [3:0] OFF_STAT    = 4'd2;
    localparam logic [3:0] OFF_INTSTK  = 4'd3;
    localparam logic [3:0] OFF_INTEN   = 4'd4;
    localparam logic [3:0] OFF_SCRATCH = 4'd5;
    localparam logic [3:0] OFF_EVCNT   = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } upslv_state_e;

endpackage

// File: rtl/upslv_reg_if.sv
// Internal CPU bus as seen by one register slave: the decoder/CPU side
// drives the master modport, the register block uses the slave modport.
interface upslv_reg_if;
    import upslv_pkg::*;

    logic [ADDR_W-1:0] upa;
    logic [DATA_W-1:0] updi;
    logic              upen;
    logic              uprs;
    logic              upws;
    logic [DATA_W-1:0] updo;
    logic              uprdy;

    modport master (
        output upa, updi, upen, uprs, upws,
        input  updo, uprdy
    );

    modport slave (
        input  upa, updi, upen, uprs, upws,
        output updo, uprdy
    );
endinterface

// File: rtl/upslv_evdet.sv
// Rising-edge detector for the event inputs: a bit is flagged while it is
// high and was low at the previous clk155 edge.
module upslv_evdet
    import upslv_pkg::*;
(
    input  logic             clk155,
    input  logic             rst,
    input  logic [EVT_W-1:0] evt_i,
    output logic [EVT_W-1:0] rise_o
);
    logic [EVT_W-1:0] hist_q;

    // history of the event levels seen at the previous edge
    always_ff @(posedge clk155) begin
        if (rst) begin
            hist_q <= 8'h00;
        end else begin
            hist_q <= evt_i;
        end
    end

    assign rise_o = evt_i & ~hist_q;
endmodule

// File: rtl/upslv_reg.sv
// CPU-bus register slave: control/scratch registers, sticky event interrupt
// status with W1C, saturating event counter and a three-state access FSM.
module upslv_reg
    import upslv_pkg::*;
#(
    parameter logic [31:0] VERSION  = VERSION_DEFAULT,
    parameter int unsigned ADDR_LSB = 0
) (
    input  logic             clk155,
    input  logic             rst,
    upslv_reg_if.slave       bus,
    input  logic [EVT_W-1:0] evt,
    input  logic [31:0]      stat,
    output logic             upint,
    output logic [31:0]      ctrl
);
    upslv_state_e state_q, state_d;
    logic [3:0]   off_q, off_d;
    logic         uprdy_q, uprdy_d;
    logic [31:0]  updo_q, updo_d;
    logic [31:0]  ctrl_q, ctrl_d;
    logic [31:0]  scratch_q, scratch_d;
    logic [7:0]   intstk_q, intstk_d;
    logic [7:0]   inten_q, inten_d;
    logic [15:0]  evcnt_q, evcnt_d;
    logic         upint_q;
    logic [7:0]   rise;
    logic [7:0]   w1c;
    logic         wr_en;
    logic         rd_clr;
    logic [3:0]   addr_off;
    logic [31:0]  rd_mux;
    logic         addr_unused;

    assign addr_off    = bus.upa[ADDR_LSB +: 4];
    assign addr_unused = ^bus.upa;

    upslv_evdet u_evdet (
        .clk155 (clk155),
        .rst    (rst),
        .evt_i  (evt),
        .rise_o (rise)
    );

    // read data selected by the offset latched when the read was accepted
    always_comb begin
        rd_mux = 32'h0000_0000;
        case (off_q)
            OFF_VERSION: rd_mux = VERSION;
            OFF_CTRL:    rd_mux = ctrl_q;
            OFF_STAT:    rd_mux = stat;
            OFF_INTSTK:  rd_mux = {24'h00_0000, intstk_q};
            OFF_INTEN:   rd_mux = {24'h00_0000, inten_q};
            OFF_SCRATCH: rd_mux = scratch_q;
            OFF_EVCNT:   rd_mux = {16'h0000, evcnt_q};
            default:     rd_mux = 32'h0000_0000;
        endcase
    end

    // access FSM: next state, write enable and the registered ack/data
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wr_en   = 1'b0;
        uprdy_d = 1'b0;
        updo_d  = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (bus.upen && bus.upws) begin
                    wr_en   = 1'b1;
                    uprdy_d = 1'b1;
                    state_d = ST_ACK;
                end else if (bus.upen && bus.uprs) begin
                    off_d   = addr_off;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                uprdy_d = 1'b1;
                updo_d  = rd_mux;
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and bus outputs; updo is only non-zero alongside uprdy
    always_ff @(posedge clk155) begin
        if (rst) begin
            state_q <= ST_IDLE;
            off_q   <= 4'h0;
            uprdy_q <= 1'b0;
            updo_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            uprdy_q <= uprdy_d;
            updo_q  <= updo_d;
        end
    end

    // register file next state; an event edge wins over a same-cycle W1C
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        inten_d   = inten_q;
        w1c       = 8'h00;
        if (wr_en) begin
            case (addr_off)
                OFF_CTRL:    ctrl_d    = bus.updi;
                OFF_INTSTK:  w1c       = bus.updi[7:0];
                OFF_INTEN:   inten_d   = bus.updi[7:0];
                OFF_SCRATCH: scratch_d = bus.updi;
                default:     w1c       = 8'h00;
            endcase
        end else begin
            w1c = 8'h00;
        end
        intstk_d = (intstk_q & ~w1c) | rise;
        rd_clr   = (state_q == ST_RD) && (off_q == OFF_EVCNT);
        if (rd_clr) begin
            evcnt_d = {15'h0000, rise[0]};
        end else if (rise[0] && (evcnt_q != 16'hFFFF)) begin
            evcnt_d = evcnt_q + 16'h0001;
        end else begin
            evcnt_d = evcnt_q;
        end
    end

    // register file and the interrupt request, which trails INTSTK/INTEN by one cycle
    always_ff @(posedge clk155) begin
        if (rst) begin
            ctrl_q    <= 32'h0000_0000;
            scratch_q <= 32'h0000_0000;
            intstk_q  <= 8'h00;
            inten_q   <= 8'h00;
            evcnt_q   <= 16'h0000;
            upint_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            intstk_q  <= intstk_d;
            inten_q   <= inten_d;
            evcnt_q   <= evcnt_d;
            upint_q   <= |(intstk_q & inten_q);
        end
    end

    assign bus.uprdy = uprdy_q;
    assign bus.updo  = updo_q;
    assign upint     = upint_q;
    assign ctrl      = ctrl_q;
endmodule

// File: doc/upslv_reg.md
UPSLV_REG -- requirements
Module: upslv_reg

Interface
REQ-001 Parameter VERSION, default 32'h0001_0000, value returned by the VERSION register.
REQ-002 Parameter ADDR_LSB, default 0, lowest upa bit used for register decode (decode uses upa[ADDR_LSB+3:ADDR_LSB]).
REQ-003 clk155  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 upa  input  24  internal CPU address bus.
REQ-006 updi  input  32  internal CPU write data.
REQ-007 upen  input  1  block select from the bus decoder, level, held for the whole access.
REQ-008 uprs  input  1  read strobe, single-cycle pulse in clk155 domain.
REQ-009 upws  input  1  write strobe, single-cycle pulse in clk155 domain.
REQ-010 evt  input  8  event inputs, level; rising edge = event.
REQ-011 stat  input  32  live status word, read-only to CPU.
REQ-012 updo  output  32  read data; zero except during the ack cycle.
REQ-013 uprdy  output  1  access acknowledge, single-cycle pulse.
REQ-014 upint  output  1  level interrupt request.
REQ-015 ctrl  output  32  CTRL register contents.

Function
REQ-016 Register map (decoded offset): 0 VERSION RO; 1 CTRL RW; 2 STAT RO (stat sampled at read); 3 INTSTK sticky, write-1-to-clear, bits[7:0]; 4 INTEN RW, bits[7:0]; 5 SCRATCH RW; 6 EVCNT RO clear-on-read, bits[15:0]; 7-15 read 0, writes ignored, still acknowledged.
REQ-017 Unused upper bits of INTSTK, INTEN and EVCNT read as 0.
REQ-018 FSM states IDLE, RD, ACK; reset state IDLE.
REQ-019 IDLE: upen&upws -> commit write at the next edge, go to ACK; upen&uprs -> latch offset, go to RD; both strobes set -> write wins.
REQ-020 RD -> ACK unconditionally; RD registers the read data.
REQ-021 ACK: uprdy=1, updo=read data (0 for writes); return to IDLE.
REQ-022 Latency: write strobe in cycle N -> uprdy in N+1; read strobe in cycle N -> uprdy in N+2.
REQ-023 Strobes arriving in RD or ACK are ignored (no queueing).
REQ-024 Strobes with upen=0 are ignored; upen dropping mid-access does not abort the access.
REQ-025 updo SHALL be 32'h0 whenever uprdy=0, so outputs are safe for an OR-merged bus.
REQ-026 Event detect: a 0->1 transition on evt[i] sets INTSTK[i] one cycle after the edge is sampled.
REQ-027 Same-cycle event set and W1C on the same INTSTK bit -> bit ends set.
REQ-028 EVCNT counts rising edges of evt[0] and saturates at 16'hFFFF.
REQ-029 EVCNT is cleared when its read reaches RD; an increment in that same cycle leaves EVCNT=1.
REQ-030 upint = registered |(INTSTK & INTEN), one cycle behind the register update.

Reset
REQ-031 rst=1 on an edge: FSM to IDLE, uprdy=0, updo=0, upint=0, CTRL=0, INTEN=0, INTSTK=0, SCRATCH=0, EVCNT=0, and the evt history register loaded with 0.
REQ-032 Reset asserted mid-access abandons the access; no uprdy is issued for it after reset releases.

Structure
REQ-033 Shared package upslv_pkg holds the register offset constants, the FSM state typedef and the default VERSION.
REQ-034 One sub-module, upslv_evdet (8-bit synchronous rising-edge detector with synchronous reset), is instantiated for evt.

Verification
REQ-035 Write 32'hA5A5_0001 to SCRATCH (offset 5) -> uprdy 1 cycle after upws, updo=0; a read of offset 5 then returns 32'hA5A5_0001 with uprdy 2 cycles after uprs.
REQ-036 Pulse evt[3] with INTEN=8'h08 -> INTSTK=8'h08, upint=1; write 8'h08 to INTSTK -> upint=0 two cycles later; repeat with an evt[3] edge coinciding with the W1C -> INTSTK stays 8'h08.
REQ-037 Apply 70000 evt[0] edges -> EVCNT reads 16'hFFFF; the next read returns 0; an edge coincident with the clear -> the following read returns 1.
REQ-038 Read offset 9, then write offset 12 -> read returns 0 with uprdy, write acknowledged, no register changes; updo=0 on every non-ack cycle for the whole test.
REQ-039 Assert rst during the RD state -> no uprdy, all registers at reset values; issue a second uprs while in ACK -> ignored, only one uprdy pulse.
